// File: rtl/uart_parity_calculator_pkg.sv
// Shared UART definitions: parity mode encodings, standard character
// widths and the mode-mapping helper used by the parity calculator.
package uart_parity_calculator_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2,
      PAR_RSVD = 2'd3
   } par_mode_t;

   localparam logic [3:0] DBITS_7 = 4'd7;
   localparam logic [3:0] DBITS_8 = 4'd8;

   // Turns the XOR of the covered data bits into the transmitted parity bit.
   // Even parity sends the XOR itself so the total count of ones is even,
   // odd parity sends its complement, and "none" or the reserved code
   // always produce 0 so downstream logic sees a quiet line.
   function automatic logic apply_parity_mode(input logic x, input logic [1:0] mode);
      logic result;
      result = 1'b0;
      case (mode)
         PAR_EVEN: result = x;
         PAR_ODD:  result = ~x;
         default:  result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_parity_calculator_msb_mask_gen.sv
// Coverage mask generator: characters are MSB-aligned in the data word, so
// a character of n bits occupies the top n bit positions. The requested
// width is clamped to the storage width, and a width of zero covers nothing.
module msb_mask_gen #(
   parameter int DBIT = 8
) (
   input  logic [3:0]      dbit,
   output logic [DBIT-1:0] mask
);

   import uart_parity_calculator_pkg::*;

   localparam logic [4:0] DBIT_W = 5'(DBIT);

   logic [4:0] n_eff;
   logic [4:0] low_bound;

   // Clamp the requested width and find the lowest covered bit index.
   always_comb begin
      n_eff = {1'b0, dbit};
      if (n_eff > DBIT_W) begin
         n_eff = DBIT_W;
      end
      low_bound = DBIT_W - n_eff;
   end

   for (genvar i = 0; i < DBIT; i++) begin : g_mask
      assign mask[i] = (5'(i) >= low_bound);
   end

endmodule

// File: rtl/uart_parity_calculator.sv
// UART parity calculator. Provides a zero-latency combinational parity for
// the rx checker plus a registered, valid-qualified copy for pipelined
// users. Every in_valid cycle is accepted; there is no backpressure.
module uart_parity_calculator #(
   parameter int DBIT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [DBIT-1:0] data,
   input  logic [3:0]      dbit,
   input  logic [1:0]      pbit,
   input  logic            in_valid,
   output logic            parity_c,
   output logic            parity,
   output logic            out_valid
);

   import uart_parity_calculator_pkg::*;

   logic [DBIT-1:0] mask;
   logic [DBIT-1:0] covered;
   logic            x;

   msb_mask_gen #(
      .DBIT (DBIT)
   ) u_mask (
      .dbit (dbit),
      .mask (mask)
   );

   // Keep only the character bits, fold them to one XOR bit, map by mode.
   always_comb begin
      covered  = data & mask;
      x        = ^covered;
      parity_c = apply_parity_mode(x, pbit);
   end

   // Output register: reset wins over a simultaneous capture request.
   always_ff @(posedge clk) begin
      if (!reset) begin
         parity    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (in_valid) begin
            parity <= parity_c;
         end
         out_valid <= in_valid;
      end
   end

endmodule

// File: tb/tb_uart_parity_calculator.sv
// Self-checking bench for uart_parity_calculator: directed table of
// combinational cases, hand-written register/reset sequences, and a
// randomized run against a popcount-based reference model.
module tb_uart_parity_calculator;

   logic       clk;
   logic       reset;
   logic [7:0] data;
   logic [3:0] dbit;
   logic [1:0] pbit;
   logic       in_valid;
   logic       parity_c;
   logic       parity;
   logic       out_valid;

   int vectors;
   int miscompares;

   logic exp_parity;
   logic exp_valid;

   typedef struct {
      string      name;
      logic [7:0] data;
      logic [3:0] dbit;
      logic [1:0] pbit;
      logic       exp;
   } vec_t;

   vec_t table_vecs[$];

   uart_parity_calculator #(
      .DBIT (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .data      (data),
      .dbit      (dbit),
      .pbit      (pbit),
      .in_valid  (in_valid),
      .parity_c  (parity_c),
      .parity    (parity),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: count ones in the top min(n,8) bits, then apply the mode.
   function automatic logic model_parity(input logic [7:0] d, input logic [3:0] n,
                                         input logic [1:0] mode);
      int neff;
      int ones;
      logic [7:0] top;
      neff = (n > 4'd8) ? 8 : int'(n);
      top  = (neff == 0) ? 8'h00 : (d >> (8 - neff));
      ones = $countones(top);
      if (mode == 2'd1) return logic'(ones % 2);
      if (mode == 2'd2) return logic'(1 - (ones % 2));
      return 1'b0;
   endfunction

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic [7:0] d, input logic [3:0] n,
                                input logic [1:0] mode, input logic iv);
      @(negedge clk);
      reset    = rst;
      data     = d;
      dbit     = n;
      pbit     = mode;
      in_valid = iv;
   endtask

   // Advance through one rising edge and check the registered outputs.
   task automatic stepAndCheck(input string name, input logic ep, input logic ev);
      @(posedge clk);
      #1;
      checkOutput({name, ".parity"}, parity, ep);
      checkOutput({name, ".out_valid"}, out_valid, ev);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      data        = 8'h00;
      dbit        = 4'd8;
      pbit        = 2'd0;
      in_valid    = 1'b0;

      table_vecs.push_back('{"a5_even",   8'hA5, 4'd8,  2'd1, 1'b0});
      table_vecs.push_back('{"a5_odd",    8'hA5, 4'd8,  2'd2, 1'b1});
      table_vecs.push_back('{"07_even",   8'h07, 4'd8,  2'd1, 1'b1});
      table_vecs.push_back('{"07_odd",    8'h07, 4'd8,  2'd2, 1'b0});
      table_vecs.push_back('{"01_7_even", 8'h01, 4'd7,  2'd1, 1'b0});
      table_vecs.push_back('{"01_7_odd",  8'h01, 4'd7,  2'd2, 1'b1});
      table_vecs.push_back('{"fe_7_even", 8'hFE, 4'd7,  2'd1, 1'b1});
      table_vecs.push_back('{"ff_none",   8'hFF, 4'd8,  2'd0, 1'b0});
      table_vecs.push_back('{"ff_rsvd",   8'hFF, 4'd8,  2'd3, 1'b0});
      table_vecs.push_back('{"clamp12",   8'h07, 4'd12, 2'd2, 1'b0});
      table_vecs.push_back('{"dbit0_odd", 8'hFF, 4'd0,  2'd2, 1'b1});
      table_vecs.push_back('{"80_1_even", 8'h80, 4'd1,  2'd1, 1'b1});
      table_vecs.push_back('{"7f_1_even", 8'h7F, 4'd1,  2'd1, 1'b0});

      // Reset holds outputs low even with in_valid asserted.
      applyStimulus(1'b0, 8'h07, 4'd8, 2'd1, 1'b1);
      stepAndCheck("reset_hold", 1'b0, 1'b0);
      stepAndCheck("reset_hold2", 1'b0, 1'b0);

      // Combinational table, no captures.
      foreach (table_vecs[i]) begin
         applyStimulus(1'b1, table_vecs[i].data, table_vecs[i].dbit, table_vecs[i].pbit, 1'b0);
         #1;
         checkOutput(table_vecs[i].name, parity_c, table_vecs[i].exp);
      end

      // Single capture of A5 even.
      applyStimulus(1'b1, 8'hA5, 4'd8, 2'd1, 1'b1);
      stepAndCheck("cap_a5", 1'b0, 1'b1);

      // Back-to-back captures 01, 03, 07 with even parity.
      applyStimulus(1'b1, 8'h01, 4'd8, 2'd1, 1'b1);
      stepAndCheck("b2b_01", 1'b1, 1'b1);
      applyStimulus(1'b1, 8'h03, 4'd8, 2'd1, 1'b1);
      stepAndCheck("b2b_03", 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h07, 4'd8, 2'd1, 1'b1);
      stepAndCheck("b2b_07", 1'b1, 1'b1);

      // in_valid low: parity holds, out_valid drops.
      applyStimulus(1'b1, 8'h00, 4'd8, 2'd2, 1'b0);
      stepAndCheck("hold", 1'b1, 1'b0);

      // Reset together with in_valid discards the sample.
      applyStimulus(1'b0, 8'h01, 4'd8, 2'd1, 1'b1);
      stepAndCheck("reset_prio", 1'b0, 1'b0);

      // Randomized run against the reference model.
      exp_parity = 1'b0;
      exp_valid  = 1'b0;
      for (int k = 0; k < 300; k++) begin
         logic       r_rst;
         logic [7:0] r_data;
         logic [3:0] r_dbit;
         logic [1:0] r_pbit;
         logic       r_iv;
         logic       r_exp_c;
         r_rst  = ($urandom_range(0, 15) != 0);
         r_data = 8'($urandom);
         r_dbit = 4'($urandom_range(0, 15));
         r_pbit = 2'($urandom);
         r_iv   = 1'($urandom);
         r_exp_c = model_parity(r_data, r_dbit, r_pbit);
         applyStimulus(r_rst, r_data, r_dbit, r_pbit, r_iv);
         #1;
         checkOutput("rand_parity_c", parity_c, r_exp_c);
         if (!r_rst) begin
            exp_parity = 1'b0;
            exp_valid  = 1'b0;
         end else begin
            if (r_iv) exp_parity = r_exp_c;
            exp_valid = r_iv;
         end
         stepAndCheck("rand_reg", exp_parity, exp_valid);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_parity_calculator.md
# uart_parity_calculator

Computes the UART parity bit for a received or transmitted character of 7 or 8 data bits, with even, odd or no parity. It sits beside the UART rx/tx FSMDs. The rx path uses the zero-latency combinational output to check the parity bit in the same cycle. A registered, valid-qualified copy is provided for pipelined users.

## Interface
Parameters:
- DBIT, 8, width of the data word (storage width). Legal range is 1..15.

Ports:
- clk  in  1  Single clock. All registers update on the rising edge.
- reset  in  1  Synchronous, active-low reset.
- data  in  DBIT  Character bits, MSB-aligned. With dbit=N, the character occupies data[DBIT-1 : DBIT-N]; lower bits are ignored.
- dbit  in  4  Number of data bits (normally 7 or 8).
- pbit  in  2  Parity mode: 0 = none, 1 = even, 2 = odd, 3 = reserved (treated as none).
- in_valid  in  1  Captures the current computation into the output register.
- parity_c  out  1  Combinational parity of the current inputs.
- parity  out  1  Registered parity.
- out_valid  out  1  High for one cycle when `parity` has been updated.

## Operation
- Coverage mask: bit i of `data` is covered iff i >= DBIT - n_eff, where n_eff = min(dbit, DBIT). With dbit=0, nothing is covered.
- x = XOR reduction of the covered bits.
- Mode mapping:
  - pbit=1 (even): parity_c = x, so the covered ones plus the parity bit total an even count.
  - pbit=2 (odd): parity_c = ~x.
  - pbit=0 or 3: parity_c = 0.
- parity_c is purely combinational, with no dependence on clk or reset.
- Register stage:
  - When in_valid=1: parity <= parity_c and out_valid <= 1.
  - Otherwise: parity holds its value and out_valid <= 0.
- There is no state machine. There is no backpressure: every in_valid cycle is accepted.

## Timing
- parity_c: zero-cycle latency from data, dbit and pbit.
- parity and out_valid: one-cycle latency. Inputs sampled at edge k appear after edge k.
- Back-to-back in_valid produces out_valid on consecutive cycles, each reflecting its own sample.
- Reset:
  - reset=0 at an edge forces parity=0 and out_valid=0, regardless of in_valid.
  - Reset takes priority over a simultaneous in_valid; that sample is discarded.
  - The first capture after release is the first edge with reset=1 and in_valid=1.
- Changing dbit or pbit mid-stream affects only samples taken after the change.
- dbit > DBIT is clamped to DBIT. This is not an error.

## Structure
- Shared UART package:
  - PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2.
  - DBITS_7 = 4'd7, DBITS_8 = 4'd8.
- One natural sub-module, `msb_mask_gen`. It maps (dbit, DBIT) to the DBIT-wide coverage mask using clamping.
- The top level ANDs the mask with data, XOR-reduces the result, applies the mode mapping, and holds the output register.

## Test plan
- Even and odd, 8-bit:
  - data=8'hA5, dbit=8, pbit=1 -> parity_c=0. Pulse in_valid -> parity=0, out_valid=1 next cycle.
  - Same data with pbit=2 -> parity_c=1.
- Odd ones count: data=8'h07, dbit=8 -> even gives 1, odd gives 0.
- 7-bit alignment: data=8'h01, dbit=7 -> bit0 excluded. Even gives 0, odd gives 1. data=8'hFE, dbit=7 (7 ones) -> even gives 1.
- Disabled modes: pbit=0 and pbit=3 with data=8'hFF -> parity_c=0.
- Clamp and edge cases, with odd parity:
  - dbit=12, data=8'h07 -> result equals dbit=8 (parity_c=0).
  - dbit=0 -> parity_c=1.
- Handshake and reset:
  - in_valid high for 3 cycles with data 8'h01, 8'h03, 8'h07 (dbit=8, even) -> out_valid high for 3 cycles; parity sequence 1, 0, 1.
  - Then reset=0 together with in_valid=1 -> parity=0, out_valid=0 after the edge.
